// File: rtl/psum_ofifo_pkg.sv
// psum_ofifo_pkg: sizing defaults and pointer-width helper shared by the psum output buffer
package psum_ofifo_pkg;
    localparam int PSUM_BW = 16;
    localparam int COL = 8;
    localparam int DEPTH = 8;
    function automatic int ptr_w(input int d);
        return $clog2(d);
    endfunction
endpackage

// File: rtl/psum_col_fifo.sv
// psum_col_fifo: single-column first-word-fall-through FIFO with sticky overflow flag
module psum_col_fifo
    import psum_ofifo_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int depth = DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic                   push,
    input  logic                   pop,
    input  logic [psum_bw-1:0]     din,
    output logic [psum_bw-1:0]     dout,
    output logic [ptr_w(depth):0]  count,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow
);
    localparam int aw = ptr_w(depth);
    logic [psum_bw-1:0] mem [depth];
    logic [aw-1:0] wr_ptr, rd_ptr;
    logic wr_en;
    assign full = count == (aw+1)'(depth);
    assign empty = count == '0;
    // a pop on the same edge frees the slot, so a full column still accepts the write
    assign wr_en = push & (~full | pop);
    assign dout = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + aw'(1);
            if (pop) rd_ptr <= rd_ptr + aw'(1);
            count <= count + (aw+1)'(wr_en) - (aw+1)'(pop);
            if (push & full & ~pop) overflow <= 1'b1;
        end
    always_ff @(posedge clk)
        if (wr_en & ~clr) mem[wr_ptr] <= din;
endmodule

// File: rtl/psum_ofifo.sv
// psum_ofifo: per-column psum FIFOs that realign skewed mac_row outputs into whole rows
module psum_ofifo
    import psum_ofifo_pkg::*;
#(
    parameter int col = COL,
    parameter int psum_bw = PSUM_BW,
    parameter int depth = DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic [col-1:0]         o_overflow
);
    logic [col-1:0] empty, full;
    logic pop;
    assign o_valid = &(~empty);
    assign o_full = |full;
    assign o_ready = ~o_full;
    // a row leaves only when every column has its entry
    assign pop = rd & o_valid;
    for (genvar i = 0; i < col; i++) begin : g_col
        logic [ptr_w(depth):0] count;
        psum_col_fifo #(.psum_bw(psum_bw), .depth(depth)) u_fifo (
            .clk(clk),
            .reset(reset),
            .clr(clr),
            .push(wr[i]),
            .pop(pop),
            .din(in[psum_bw*i +: psum_bw]),
            .dout(out[psum_bw*i +: psum_bw]),
            .count(count),
            .full(full[i]),
            .empty(empty[i]),
            .overflow(o_overflow[i])
        );
        a_count_bound: assert property (@(posedge clk) disable iff (!reset) count <= (ptr_w(depth)+1)'(depth));
    end
endmodule
